fu_issue_queue: RTL and testbench

Per-functional-unit in-order issue queue between the dispatch stage and one execution unit (ALU, MAC, LD, ST, MSK or SLD). It buffers dispatched requests and hands them to the unit over a valid/ready handshake. It tracks each issued instruction until its sources are read and its destination is written, and returns per-slot vs/vd completion pulses to the dispatch scoreboard. One instance exists per unit.

---
 rtl/fu_issue_queue_pkg.sv | 31 +++
 rtl/fu_issue_queue_ptr_ctrl.sv | 96 +++++++++
 rtl/fu_issue_queue.sv | 91 +++++++++
 tb/tb_fu_issue_queue.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fu_issue_queue_pkg.sv
// Shared types for the per-unit in-order issue queue: decoded request,
// functional-unit tag and the life-cycle state of one queue entry.
package fu_issue_queue_pkg;

    localparam int ID_W = 3;

    typedef enum logic [2:0] {
        FU_ALU = 3'd0,
        FU_MAC = 3'd1,
        FU_LD  = 3'd2,
        FU_ST  = 3'd3,
        FU_MSK = 3'd4,
        FU_SLD = 3'd5
    } fu_e;

    typedef struct packed {
        fu_e        fu;
        logic [5:0] op;
        logic [4:0] vd;
        logic [4:0] vs1;
        logic [4:0] vs2;
    } dec_req_t;

    typedef enum logic [1:0] {
        ST_FREE     = 2'd0,
        ST_QUEUED   = 2'd1,
        ST_ISSUED   = 2'd2,
        ST_SRC_DONE = 2'd3
    } ent_state_e;

endpackage

// File: rtl/fu_issue_queue_ptr_ctrl.sv
// Pointer, occupancy and entry-state bookkeeping for the issue queue, plus
// detection of done pulses that do not match any tracked entry.
module fu_issue_queue_ptr_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dp_valid_i,
    input  logic             exu_ready_i,
    input  logic             vs_done_i,
    input  logic             vd_done_i,
    output logic             dp_ready_o,
    output logic             accept_o,
    output logic             iss_valid_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] iss_ptr_o,
    output logic [PTR_W-1:0] vs_ptr_o,
    output logic [PTR_W-1:0] rt_ptr_o,
    output logic             resp_vs_o,
    output logic             resp_vd_o,
    output logic             proto_err_o
);
    import fu_issue_queue_pkg::*;

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;

    ent_state_e       st_q [DEPTH];
    logic [PTR_W-1:0] wr_q, iss_q, vs_q, rt_q;
    logic [PTR_W:0]   cnt_q;
    logic             err_q;

    logic iss, vs_hit, rt_src, rt_iss, vd_ret, vs_adv, err_now;

    always_comb begin
        dp_ready_o  = (cnt_q != FULL_CNT);
        accept_o    = dp_valid_i & dp_ready_o;
        iss_valid_o = (st_q[iss_q] == ST_QUEUED);
        iss         = iss_valid_o & exu_ready_i;
        vs_hit      = vs_done_i & (st_q[vs_q] == ST_ISSUED);
        rt_src      = (st_q[rt_q] == ST_SRC_DONE);
        rt_iss      = (st_q[rt_q] == ST_ISSUED);
        vd_ret      = vd_done_i & (rt_src | rt_iss);
        // A retire of a still-ISSUED entry implies vs_ptr==rt_ptr, so the source
        // read completes on the same entry.
        vs_adv      = vs_hit | (vd_done_i & rt_iss);
        err_now     = (vs_done_i & ~vs_hit)
                    | (vd_done_i & ~rt_src & ~rt_iss)
                    | (vd_done_i & rt_iss & ~vs_done_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) st_q[i] <= ST_FREE;
            wr_q  <= '0;
            iss_q <= '0;
            vs_q  <= '0;
            rt_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept_o) begin
                st_q[wr_q] <= ST_QUEUED;
                wr_q       <= wr_q + PTR_ONE;
            end
            if (iss) begin
                st_q[iss_q] <= ST_ISSUED;
                iss_q       <= iss_q + PTR_ONE;
            end
            if (vs_hit) st_q[vs_q] <= ST_SRC_DONE;
            if (vs_adv) vs_q <= vs_q + PTR_ONE;
            // Placed last so a combined vs/vd on one entry ends up FREE.
            if (vd_ret) begin
                st_q[rt_q] <= ST_FREE;
                rt_q       <= rt_q + PTR_ONE;
            end
            case ({accept_o, vd_ret})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
            err_q <= err_q | err_now;
        end
    end

    assign wr_ptr_o    = wr_q;
    assign iss_ptr_o   = iss_q;
    assign vs_ptr_o    = vs_q;
    assign rt_ptr_o    = rt_q;
    assign resp_vs_o   = vs_adv;
    assign resp_vd_o   = vd_ret;
    assign proto_err_o = err_q;

endmodule

// File: rtl/fu_issue_queue.sv
// In-order issue queue for one execution unit: buffers dispatched requests,
// issues them over valid/ready and reports source-read and write completion.
module fu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int ID_W  = fu_issue_queue_pkg::ID_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          dp_req_valid_i,
    output logic                          dp_req_ready_o,
    input  fu_issue_queue_pkg::dec_req_t  dp_req_i,
    input  logic [ID_W-1:0]               dp_id_i,
    output logic                          q_empty_o,
    output logic                          exu_req_valid_o,
    input  logic                          exu_req_ready_i,
    output fu_issue_queue_pkg::dec_req_t  exu_req_o,
    output logic [ID_W-1:0]               exu_id_o,
    input  logic                          exu_vs_done_i,
    input  logic                          exu_vd_done_i,
    output logic                          resp_vs_valid_o,
    output logic [ID_W-1:0]               resp_vs_id_o,
    output logic                          resp_vd_valid_o,
    output logic [ID_W-1:0]               resp_vd_id_o,
    output logic                          proto_err_o
);
    import fu_issue_queue_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    dec_req_t         req_q [DEPTH];
    logic [ID_W-1:0]  id_q  [DEPTH];
    logic [PTR_W-1:0] wr_ptr, iss_ptr, vs_ptr, rt_ptr;
    logic             accept, resp_vs, resp_vd;
    logic             resp_vs_valid_q, resp_vd_valid_q;
    logic [ID_W-1:0]  resp_vs_id_q, resp_vd_id_q;

    fu_issue_queue_ptr_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ptr_ctrl (
        .clk         (clk),
        .rst         (rst),
        .dp_valid_i  (dp_req_valid_i),
        .exu_ready_i (exu_req_ready_i),
        .vs_done_i   (exu_vs_done_i),
        .vd_done_i   (exu_vd_done_i),
        .dp_ready_o  (dp_req_ready_o),
        .accept_o    (accept),
        .iss_valid_o (exu_req_valid_o),
        .wr_ptr_o    (wr_ptr),
        .iss_ptr_o   (iss_ptr),
        .vs_ptr_o    (vs_ptr),
        .rt_ptr_o    (rt_ptr),
        .resp_vs_o   (resp_vs),
        .resp_vd_o   (resp_vd),
        .proto_err_o (proto_err_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                req_q[i] <= '0;
                id_q[i]  <= '0;
            end
        end else if (accept) begin
            req_q[wr_ptr] <= dp_req_i;
            id_q[wr_ptr]  <= dp_id_i;
        end
    end

    // Ids are sampled from the pre-edge pointers, i.e. the entries the pulses target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_vs_valid_q <= 1'b0;
            resp_vs_id_q    <= '0;
            resp_vd_valid_q <= 1'b0;
            resp_vd_id_q    <= '0;
        end else begin
            resp_vs_valid_q <= resp_vs;
            resp_vs_id_q    <= resp_vs ? id_q[vs_ptr] : '0;
            resp_vd_valid_q <= resp_vd;
            resp_vd_id_q    <= resp_vd ? id_q[rt_ptr] : '0;
        end
    end

    assign exu_req_o       = req_q[iss_ptr];
    assign exu_id_o        = id_q[iss_ptr];
    assign q_empty_o       = ~exu_req_valid_o;
    assign resp_vs_valid_o = resp_vs_valid_q;
    assign resp_vs_id_o    = resp_vs_id_q;
    assign resp_vd_valid_o = resp_vd_valid_q;
    assign resp_vd_id_o    = resp_vd_id_q;

endmodule

// File: tb/tb_fu_issue_queue.sv
// Bench for fu_issue_queue: ordered-list reference model, per-cycle compare,
// directed scenarios with literal expectations and a randomized phase.
module tb_fu_issue_queue;
    import fu_issue_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int IDW   = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           dp_req_valid_i = 1'b0;
    logic           dp_req_ready_o;
    dec_req_t       dp_req_i = '0;
    logic [IDW-1:0] dp_id_i = '0;
    logic           q_empty_o;
    logic           exu_req_valid_o;
    logic           exu_req_ready_i = 1'b0;
    dec_req_t       exu_req_o;
    logic [IDW-1:0] exu_id_o;
    logic           exu_vs_done_i = 1'b0;
    logic           exu_vd_done_i = 1'b0;
    logic           resp_vs_valid_o;
    logic [IDW-1:0] resp_vs_id_o;
    logic           resp_vd_valid_o;
    logic [IDW-1:0] resp_vd_id_o;
    logic           proto_err_o;

    fu_issue_queue #(.DEPTH(DEPTH), .ID_W(IDW)) dut (
        .clk             (clk),
        .rst             (rst),
        .dp_req_valid_i  (dp_req_valid_i),
        .dp_req_ready_o  (dp_req_ready_o),
        .dp_req_i        (dp_req_i),
        .dp_id_i         (dp_id_i),
        .q_empty_o       (q_empty_o),
        .exu_req_valid_o (exu_req_valid_o),
        .exu_req_ready_i (exu_req_ready_i),
        .exu_req_o       (exu_req_o),
        .exu_id_o        (exu_id_o),
        .exu_vs_done_i   (exu_vs_done_i),
        .exu_vd_done_i   (exu_vd_done_i),
        .resp_vs_valid_o (resp_vs_valid_o),
        .resp_vs_id_o    (resp_vs_id_o),
        .resp_vd_valid_o (resp_vd_valid_o),
        .resp_vd_id_o    (resp_vd_id_o),
        .proto_err_o     (proto_err_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: oldest-first list; st 0 = waiting, 1 = handed to unit, 2 = sources read.
    typedef struct {
        logic [IDW-1:0] id;
        dec_req_t       req;
        int             st;
    } ent_t;

    ent_t           lst[$];
    bit             m_err, m_rvs_v, m_rvd_v;
    logic [IDW-1:0] m_rvs_id, m_rvd_id;

    function automatic int count_st(int s);
        int n = 0;
        foreach (lst[i]) if (lst[i].st == s) n++;
        return n;
    endfunction

    function automatic void model_reset();
        lst.delete();
        m_err   = 1'b0;
        m_rvs_v = 1'b0;
        m_rvd_v = 1'b0;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            int   nsd, ni, nq;
            bit   vs_ok, vd_ok, vd_iss, take, give;
            ent_t e;
            nsd    = count_st(2);
            ni     = count_st(1);
            nq     = count_st(0);
            take   = dp_req_valid_i && (lst.size() < DEPTH);
            give   = (nq > 0) && exu_req_ready_i;
            vs_ok  = exu_vs_done_i && (ni > 0);
            vd_ok  = exu_vd_done_i && ((nsd + ni) > 0);
            vd_iss = vd_ok && (nsd == 0);
            if ((exu_vs_done_i && !vs_ok) || (exu_vd_done_i && !vd_ok) ||
                (vd_iss && !exu_vs_done_i))
                m_err = 1'b1;
            m_rvs_v = vs_ok || vd_iss;
            if (m_rvs_v) m_rvs_id = lst[nsd].id;
            m_rvd_v = vd_ok;
            if (vd_ok) m_rvd_id = lst[0].id;
            if (vs_ok) lst[nsd].st = 2;
            if (give) lst[nsd + ni].st = 1;
            if (vd_ok) void'(lst.pop_front());
            if (take) begin
                e.id  = dp_id_i;
                e.req = dp_req_i;
                e.st  = 0;
                lst.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && chk_on) begin
            int nsd, ni, nq;
            nsd = count_st(2);
            ni  = count_st(1);
            nq  = count_st(0);
            chk("dp_req_ready", 32'(dp_req_ready_o), 32'(lst.size() < DEPTH));
            chk("exu_req_valid", 32'(exu_req_valid_o), 32'(nq > 0));
            chk("q_empty", 32'(q_empty_o), 32'(nq == 0));
            if (nq > 0) begin
                chk("exu_id", 32'(exu_id_o), 32'(lst[nsd + ni].id));
                chk("exu_req", 32'(exu_req_o), 32'(lst[nsd + ni].req));
            end
            chk("resp_vs_valid", 32'(resp_vs_valid_o), 32'(m_rvs_v));
            if (m_rvs_v) chk("resp_vs_id", 32'(resp_vs_id_o), 32'(m_rvs_id));
            chk("resp_vd_valid", 32'(resp_vd_valid_o), 32'(m_rvd_v));
            if (m_rvd_v) chk("resp_vd_id", 32'(resp_vd_id_o), 32'(m_rvd_id));
            chk("proto_err", 32'(proto_err_o), 32'(m_err));
        end
    end

    function automatic dec_req_t rand_req();
        logic [31:0] r;
        r = $urandom;
        return dec_req_t'(r[$bits(dec_req_t)-1:0]);
    endfunction

    task automatic cyc(bit v, logic [IDW-1:0] id, bit er, bit vs, bit vd);
        dp_req_valid_i  = v;
        dp_id_i         = id;
        dp_req_i        = rand_req();
        exu_req_ready_i = er;
        exu_vs_done_i   = vs;
        exu_vd_done_i   = vd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        model_reset();
        dp_req_valid_i  = 1'b0;
        exu_req_ready_i = 1'b0;
        exu_vs_done_i   = 1'b0;
        exu_vd_done_i   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst dp_req_ready", 32'(dp_req_ready_o), 32'd1);
        chk("rst q_empty", 32'(q_empty_o), 32'd1);
        chk("rst exu_req_valid", 32'(exu_req_valid_o), 32'd0);
        chk("rst exu_id", 32'(exu_id_o), 32'd0);
        chk("rst exu_req", 32'(exu_req_o), 32'd0);
        chk("rst resp_vs", {resp_vs_valid_o, resp_vs_id_o}, 32'd0);
        chk("rst resp_vd", {resp_vd_valid_o, resp_vd_id_o}, 32'd0);
        chk("rst proto_err", 32'(proto_err_o), 32'd0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        chk_on = 1'b1;
        chk_reset_outputs();

        // Reset with three entries held
        cyc(1, 3'd1, 0, 0, 0);
        cyc(1, 3'd2, 0, 0, 0);
        cyc(1, 3'd3, 0, 0, 0);
        do_reset();
        chk_reset_outputs();
        cyc(0, 3'd0, 0, 0, 0);
        chk("post-rst no resp", {resp_vs_valid_o, resp_vd_valid_o}, 32'd0);

        // Fill, then retire while full and dispatch pending
        cyc(1, 3'd1, 0, 0, 0);
        cyc(1, 3'd2, 0, 0, 0);
        cyc(1, 3'd3, 0, 0, 0);
        cyc(1, 3'd4, 0, 0, 0);
        chk("fill ready", 32'(dp_req_ready_o), 32'd0);
        chk("fill exu_id", 32'(exu_id_o), 32'd1);
        cyc(1, 3'd5, 0, 0, 0);
        chk("fill held exu_id", 32'(exu_id_o), 32'd1);
        chk("fill held ready", 32'(dp_req_ready_o), 32'd0);
        cyc(0, 3'd0, 1, 0, 0);
        chk("issue next id", 32'(exu_id_o), 32'd2);
        cyc(0, 3'd0, 0, 1, 0);
        chk("full vs id", {resp_vs_valid_o, resp_vs_id_o}, {29'd1, 3'd1});
        cyc(1, 3'd5, 0, 0, 1);
        chk("full vd id", {resp_vd_valid_o, resp_vd_id_o}, {29'd1, 3'd1});
        chk("full ready after retire", 32'(dp_req_ready_o), 32'd1);
        cyc(1, 3'd5, 0, 0, 0);
        chk("full again", 32'(dp_req_ready_o), 32'd0);

        // In-order issue and completion
        do_reset();
        cyc(1, 3'd5, 0, 0, 0);
        cyc(1, 3'd6, 0, 0, 0);
        cyc(0, 3'd0, 1, 0, 0);
        cyc(0, 3'd0, 1, 0, 0);
        chk("both issued q_empty", 32'(q_empty_o), 32'd1);
        cyc(0, 3'd0, 0, 1, 0);
        chk("vs 5", {resp_vs_valid_o, resp_vs_id_o}, {29'd1, 3'd5});
        cyc(0, 3'd0, 0, 1, 0);
        chk("vs 6", {resp_vs_valid_o, resp_vs_id_o}, {29'd1, 3'd6});
        cyc(0, 3'd0, 0, 0, 1);
        chk("vd 5", {resp_vd_valid_o, resp_vd_id_o}, {29'd1, 3'd5});
        chk("vs pulse ended", 32'(resp_vs_valid_o), 32'd0);
        cyc(0, 3'd0, 0, 0, 1);
        chk("vd 6", {resp_vd_valid_o, resp_vd_id_o}, {29'd1, 3'd6});
        cyc(0, 3'd0, 0, 0, 0);
        chk("vd pulse ended", 32'(resp_vd_valid_o), 32'd0);

        // Combined vs/vd on a single entry
        cyc(1, 3'd7, 0, 0, 0);
        cyc(0, 3'd0, 1, 0, 0);
        cyc(0, 3'd0, 0, 1, 1);
        chk("comb vs", {resp_vs_valid_o, resp_vs_id_o}, {29'd1, 3'd7});
        chk("comb vd", {resp_vd_valid_o, resp_vd_id_o}, {29'd1, 3'd7});
        chk("comb no err", 32'(proto_err_o), 32'd0);
        chk("comb empty", 32'(q_empty_o), 32'd1);

        // Protocol errors
        cyc(1, 3'd2, 0, 0, 0);
        cyc(0, 3'd0, 1, 0, 0);
        cyc(0, 3'd0, 0, 0, 1);
        chk("err vs", {resp_vs_valid_o, resp_vs_id_o}, {29'd1, 3'd2});
        chk("err vd", {resp_vd_valid_o, resp_vd_id_o}, {29'd1, 3'd2});
        chk("err set", 32'(proto_err_o), 32'd1);
        cyc(0, 3'd0, 0, 1, 0);
        chk("stray vs ignored", 32'(resp_vs_valid_o), 32'd0);
        chk("err sticky", 32'(proto_err_o), 32'd1);
        cyc(0, 3'd0, 0, 0, 0);
        chk("err still sticky", 32'(proto_err_o), 32'd1);

        // Randomized traffic, mostly legal, occasional stray done pulses
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int nsd, ni;
            bit v, er, vs, vd;
            if (c % 800 == 799) do_reset();
            nsd = count_st(2);
            ni  = count_st(1);
            v   = ($urandom_range(0, 2) != 0);
            er  = ($urandom_range(0, 3) != 0);
            vs  = (ni > 0) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 40) == 0);
            vd  = (nsd > 0) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 40) == 0);
            cyc(v, 3'($urandom_range(0, 7)), er, vs, vd);
        end

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
